// File: rtl/aw_router_pkg.sv
// Shared AXI-lite interconnect definitions: slave count, select width, the
// default/error slave index and the write-path state encoding. Also used by
// the B-channel response router and the future read-address router.
package aw_router_pkg;

    localparam int NUM_SLAVES = 5;
    localparam int SEL_W      = 3;

    typedef logic [SEL_W-1:0]      sel_t;
    typedef logic [NUM_SLAVES-1:0] slv_vec_t;

    // Unmapped regions land on the last slave, which answers with an error.
    localparam sel_t DEFAULT_SLAVE = 3'd4;

    // Write-path phases: wait for AW, forward AW, forward W, wait for B.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AW   = 2'd1,
        ST_W    = 2'd2,
        ST_B    = 2'd3
    } wr_state_e;

    // One-hot slave vector for a select index; out-of-range indices give 0.
    function automatic slv_vec_t sel_onehot(input sel_t sel);
        slv_vec_t vec;
        vec = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel == sel_t'(i)) begin
                vec[i] = 1'b1;
            end
        end
        return vec;
    endfunction

    // Pick the bit of a per-slave vector belonging to the selected slave.
    function automatic logic sel_bit(input slv_vec_t vec, input sel_t sel);
        return |(vec & sel_onehot(sel));
    endfunction

endpackage

// File: rtl/aw_router_addr_decode.sv
// Combinational address-to-slave decoder. The 3-bit region field above the
// 4 KB page offset picks the slave; regions beyond the last slave go to the
// default/error slave. Shared with the read-address router.
module aw_addr_decode
    import aw_router_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int SEL_LSB = 12
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [SEL_W-1:0]  sel
);

    sel_t region;
    logic unused_addr_bits;

    // Only the region field matters; the rest of the address is ignored here.
    assign unused_addr_bits = ^{addr[ADDR_W-1:SEL_LSB+3], addr[SEL_LSB-1:0]};

    // Map region 0..NUM_SLAVES-1 directly, everything above to the default slave.
    always_comb begin
        region = addr[SEL_LSB+2:SEL_LSB];
        if (region < sel_t'(NUM_SLAVES)) begin
            sel = region;
        end else begin
            sel = DEFAULT_SLAVE;
        end
    end

endmodule

// File: rtl/aw_router.sv
// Write-path front end of the AXI-lite interconnect. Accepts one AW from the
// master, decodes it to a slave, forwards AW then W to that slave and holds
// aw_sel_q stable until the master sees its B handshake, so the B router can
// steer the response. Only one write is ever in flight.
module aw_router
    import aw_router_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int SEL_LSB = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // Master AW channel
    input  logic [ADDR_W-1:0]     m_awaddr,
    input  logic                  m_awvalid,
    output logic                  m_awready,

    // Master W channel
    input  logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_wvalid,
    output logic                  m_wready,

    // Master B channel, observed only
    input  logic                  m_bvalid,
    input  logic                  m_bready,

    // Slave AW channel
    output logic [ADDR_W-1:0]     s_awaddr,
    output logic                  s_awvalid0,
    output logic                  s_awvalid1,
    output logic                  s_awvalid2,
    output logic                  s_awvalid3,
    output logic                  s_awvalid4,
    input  logic                  s_awready0,
    input  logic                  s_awready1,
    input  logic                  s_awready2,
    input  logic                  s_awready3,
    input  logic                  s_awready4,

    // Slave W channel
    output logic [DATA_W-1:0]     s_wdata,
    output logic [DATA_W/8-1:0]   s_wstrb,
    output logic                  s_wvalid0,
    output logic                  s_wvalid1,
    output logic                  s_wvalid2,
    output logic                  s_wvalid3,
    output logic                  s_wvalid4,
    input  logic                  s_wready0,
    input  logic                  s_wready1,
    input  logic                  s_wready2,
    input  logic                  s_wready3,
    input  logic                  s_wready4,

    // Registered slave index for the B router
    output logic [SEL_W-1:0]      aw_sel_q
);

    wr_state_e         state_q,   state_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    sel_t              aw_sel_d;
    slv_vec_t          awvalid_q, awvalid_d;
    logic              awready_q, awready_d;

    sel_t              dec_sel;
    slv_vec_t          s_awready_vec;
    slv_vec_t          s_wready_vec;
    slv_vec_t          s_wvalid_vec;
    logic              sel_awready;
    logic              sel_wready;
    logic              aw_accept;
    logic              w_xfer;
    logic              b_xfer;

    aw_addr_decode #(
        .ADDR_W  (ADDR_W),
        .SEL_LSB (SEL_LSB)
    ) u_decode (
        .addr (m_awaddr),
        .sel  (dec_sel)
    );

    assign s_awready_vec = {s_awready4, s_awready3, s_awready2, s_awready1, s_awready0};
    assign s_wready_vec  = {s_wready4,  s_wready3,  s_wready2,  s_wready1,  s_wready0};

    assign sel_awready = sel_bit(s_awready_vec, aw_sel_q);
    assign sel_wready  = sel_bit(s_wready_vec,  aw_sel_q);

    // awready_q is high exactly while idle, so it doubles as the IDLE qualifier.
    assign aw_accept = m_awvalid & awready_q;
    assign w_xfer    = (state_q == ST_W) & m_wvalid & sel_wready;
    assign b_xfer    = m_bvalid & m_bready;

    // Next-state and registered-output logic for the write-path sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves one unassigned and no latch is inferred.
        state_d   = state_q;
        addr_d    = addr_q;
        aw_sel_d  = aw_sel_q;
        awvalid_d = awvalid_q;
        awready_d = awready_q;

        unique case (state_q)
            ST_IDLE: begin
                if (aw_accept) begin
                    state_d   = ST_AW;
                    addr_d    = m_awaddr;
                    aw_sel_d  = dec_sel;
                    awvalid_d = sel_onehot(dec_sel);
                    awready_d = 1'b0;
                end
            end
            ST_AW: begin
                if (sel_awready) begin
                    state_d   = ST_W;
                    awvalid_d = '0;
                end
            end
            ST_W: begin
                if (w_xfer) begin
                    state_d = ST_B;
                end
            end
            ST_B: begin
                if (b_xfer) begin
                    state_d   = ST_IDLE;
                    awready_d = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                awvalid_d = '0;
                awready_d = 1'b1;
            end
        endcase
    end

    // State, latched address, select and AW-side handshake registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the address register is reset along with the control state so
        // s_awaddr shows a defined value straight out of reset.
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            aw_sel_q  <= '0;
            awvalid_q <= '0;
            awready_q <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            state_q   <= state_d;
            addr_q    <= addr_d;
            aw_sel_q  <= aw_sel_d;
            awvalid_q <= awvalid_d;
            awready_q <= awready_d;
        end
    end

    // W channel is a straight pass-through to/from the selected slave, W state only.
    always_comb begin
        s_wvalid_vec = '0;
        m_wready     = 1'b0;
        if (state_q == ST_W) begin
            s_wvalid_vec = m_wvalid ? sel_onehot(aw_sel_q) : '0;
            m_wready     = sel_wready;
        end
    end

    assign m_awready  = awready_q;
    assign s_awaddr   = addr_q;
    assign s_wdata    = m_wdata;
    assign s_wstrb    = m_wstrb;

    assign s_awvalid0 = awvalid_q[0];
    assign s_awvalid1 = awvalid_q[1];
    assign s_awvalid2 = awvalid_q[2];
    assign s_awvalid3 = awvalid_q[3];
    assign s_awvalid4 = awvalid_q[4];

    assign s_wvalid0  = s_wvalid_vec[0];
    assign s_wvalid1  = s_wvalid_vec[1];
    assign s_wvalid2  = s_wvalid_vec[2];
    assign s_wvalid3  = s_wvalid_vec[3];
    assign s_wvalid4  = s_wvalid_vec[4];

endmodule

// File: tb/tb_aw_router.sv
// Directed bench for aw_router. Inputs change and outputs are sampled on the
// falling edge; the DUT acts on the rising edge.
module tb_aw_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] m_awaddr;
    logic        m_awvalid;
    logic        m_awready;
    logic [31:0] m_wdata;
    logic [3:0]  m_wstrb;
    logic        m_wvalid;
    logic        m_wready;
    logic        m_bvalid;
    logic        m_bready;
    logic [31:0] s_awaddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic [4:0]  s_awr;
    logic [4:0]  s_wr;
    logic [4:0]  awv;
    logic [4:0]  wv;
    logic [2:0]  aw_sel_q;

    // Compact observation word: {m_awready, m_wready, s_awvalid[4:0], s_wvalid[4:0], aw_sel_q}
    logic [14:0] obs;
    logic [14:0] exp_st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    aw_router dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m_awaddr   (m_awaddr),
        .m_awvalid  (m_awvalid),
        .m_awready  (m_awready),
        .m_wdata    (m_wdata),
        .m_wstrb    (m_wstrb),
        .m_wvalid   (m_wvalid),
        .m_wready   (m_wready),
        .m_bvalid   (m_bvalid),
        .m_bready   (m_bready),
        .s_awaddr   (s_awaddr),
        .s_awvalid0 (awv[0]),
        .s_awvalid1 (awv[1]),
        .s_awvalid2 (awv[2]),
        .s_awvalid3 (awv[3]),
        .s_awvalid4 (awv[4]),
        .s_awready0 (s_awr[0]),
        .s_awready1 (s_awr[1]),
        .s_awready2 (s_awr[2]),
        .s_awready3 (s_awr[3]),
        .s_awready4 (s_awr[4]),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_wvalid0  (wv[0]),
        .s_wvalid1  (wv[1]),
        .s_wvalid2  (wv[2]),
        .s_wvalid3  (wv[3]),
        .s_wvalid4  (wv[4]),
        .s_wready0  (s_wr[0]),
        .s_wready1  (s_wr[1]),
        .s_wready2  (s_wr[2]),
        .s_wready3  (s_wr[3]),
        .s_wready4  (s_wr[4]),
        .aw_sel_q   (aw_sel_q)
    );

    assign obs = {m_awready, m_wready, awv, wv, aw_sel_q};

    function automatic logic [14:0] st(input logic awr, input logic wr,
                                       input logic [4:0] a, input logic [4:0] w,
                                       input logic [2:0] s);
        return {awr, wr, a, w, s};
    endfunction

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive-only: from AW with m_awvalid low, run W and B with all readys high.
    task automatic finish_txn;
        s_awr    = 5'h1F;
        s_wr     = 5'h1F;
        m_wvalid = 1'b1;
        tick();
        tick();
        m_wvalid = 1'b0;
        m_bvalid = 1'b1;
        m_bready = 1'b1;
        tick();
        m_bvalid = 1'b0;
        m_bready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; m_awaddr = '0; m_awvalid = 1'b0; m_wdata = '0; m_wstrb = '0;
        m_wvalid = 1'b0; m_bvalid = 1'b0; m_bready = 1'b0; s_awr = 5'h1F; s_wr = 5'h1F;
        @(negedge clk);
        tick();
        checks++;
        exp_st = st(1'b1, 1'b0, 5'b0, 5'b0, 3'd0);
        if (obs !== exp_st) begin
            errors++; $display("FAIL reset_state: got %h expected %h", obs, exp_st);
        end
        checks++;
        if (s_awaddr !== 32'h0) begin
            errors++; $display("FAIL reset_awaddr: got %h expected %h", s_awaddr, 32'h0);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mapped_write;
        m_awaddr = 32'h0000_2004; m_awvalid = 1'b1;
        tick();
        m_awvalid = 1'b0;
        checks++;
        exp_st = st(1'b0, 1'b0, 5'b00100, 5'b0, 3'd2);
        if (obs !== exp_st || s_awaddr !== 32'h0000_2004) begin
            errors++; $display("FAIL mapped_aw: got %h/%h expected %h/%h", obs, s_awaddr, exp_st, 32'h2004);
        end
        m_wdata = 32'hDEAD_BEEF; m_wstrb = 4'hF; m_wvalid = 1'b1;
        #1;
        checks++;
        if (obs !== exp_st) begin
            errors++; $display("FAIL mapped_w_held_in_aw: got %h expected %h", obs, exp_st);
        end
        tick();
        checks++;
        exp_st = st(1'b0, 1'b1, 5'b0, 5'b00100, 3'd2);
        if (obs !== exp_st || s_wdata !== 32'hDEAD_BEEF || s_wstrb !== 4'hF) begin
            errors++; $display("FAIL mapped_w: got %h/%h/%h expected %h/%h/%h",
                               obs, s_wdata, s_wstrb, exp_st, 32'hDEADBEEF, 4'hF);
        end
        tick();
        m_wvalid = 1'b0;
        checks++;
        exp_st = st(1'b0, 1'b0, 5'b0, 5'b0, 3'd2);
        if (obs !== exp_st) begin
            errors++; $display("FAIL mapped_b: got %h expected %h", obs, exp_st);
        end
        m_bvalid = 1'b1; m_bready = 1'b1;
        tick();
        m_bvalid = 1'b0; m_bready = 1'b0;
        checks++;
        exp_st = st(1'b1, 1'b0, 5'b0, 5'b0, 3'd2);
        if (obs !== exp_st) begin
            errors++; $display("FAIL mapped_idle_after_b: got %h expected %h", obs, exp_st);
        end
    endtask

    task automatic test_decode;
        logic [31:0] addrs [7] = '{32'h0000_0000, 32'h0000_1FFF, 32'h0001_3000, 32'h0000_4000,
                                   32'h0000_5000, 32'h0000_6000, 32'hFFFF_7FFC};
        logic [2:0]  sels  [7] = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
        for (int i = 0; i < 7; i++) begin
            m_awaddr = addrs[i]; m_awvalid = 1'b1;
            tick();
            m_awvalid = 1'b0;
            checks++;
            exp_st = st(1'b0, 1'b0, 5'b1 << sels[i], 5'b0, sels[i]);
            if (obs !== exp_st || s_awaddr !== addrs[i]) begin
                errors++; $display("FAIL decode_%h: got %h/%h expected %h/%h",
                                   addrs[i], obs, s_awaddr, exp_st, addrs[i]);
            end
            finish_txn();
        end
    endtask

    task automatic test_backpressure;
        m_awaddr = 32'h0000_1000; m_awvalid = 1'b1; s_awr = 5'b11101; s_wr = 5'b11101;
        tick();
        m_awvalid = 1'b0;
        exp_st = st(1'b0, 1'b0, 5'b00010, 5'b0, 3'd1);
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                s_awr = 5'h1F;
                #1;
            end
            checks++;
            if (obs !== exp_st || s_awaddr !== 32'h0000_1000) begin
                errors++; $display("FAIL bp_aw_cycle%0d: got %h/%h expected %h/%h",
                                   c, obs, s_awaddr, exp_st, 32'h1000);
            end
            tick();
        end
        checks++;
        exp_st = st(1'b0, 1'b0, 5'b0, 5'b0, 3'd1);
        if (obs !== exp_st) begin
            errors++; $display("FAIL bp_w_idle: got %h expected %h", obs, exp_st);
        end
        s_wr = 5'h1F;
        #1;
        checks++;
        exp_st = st(1'b0, 1'b1, 5'b0, 5'b0, 3'd1);
        if (obs !== exp_st) begin
            errors++; $display("FAIL bp_wready_mirror: got %h expected %h", obs, exp_st);
        end
        tick();
        m_wvalid = 1'b1;
        #1;
        checks++;
        exp_st = st(1'b0, 1'b1, 5'b0, 5'b00010, 3'd1);
        if (obs !== exp_st) begin
            errors++; $display("FAIL bp_wvalid_track: got %h expected %h", obs, exp_st);
        end
        s_wr = 5'b11101;
        #1;
        checks++;
        exp_st = st(1'b0, 1'b0, 5'b0, 5'b00010, 3'd1);
        if (obs !== exp_st) begin
            errors++; $display("FAIL bp_wready_low: got %h expected %h", obs, exp_st);
        end
        tick();
        checks++;
        if (obs !== exp_st) begin
            errors++; $display("FAIL bp_w_hold: got %h expected %h", obs, exp_st);
        end
        s_wr = 5'h1F;
        tick();
        m_wvalid = 1'b0;
        m_bvalid = 1'b1; m_bready = 1'b1;
        checks++;
        exp_st = st(1'b0, 1'b0, 5'b0, 5'b0, 3'd1);
        if (obs !== exp_st) begin
            errors++; $display("FAIL bp_b: got %h expected %h", obs, exp_st);
        end
        tick();
        m_bvalid = 1'b0; m_bready = 1'b0;
    endtask

    task automatic test_back_to_back;
        m_awaddr = 32'h0000_4000; m_awvalid = 1'b1;
        tick();
        m_awvalid = 1'b0; m_wvalid = 1'b1;
        tick();
        tick();
        m_wvalid = 1'b0; m_bvalid = 1'b1; m_bready = 1'b0;
        m_awaddr = 32'h0000_3000; m_awvalid = 1'b1;
        exp_st = st(1'b0, 1'b0, 5'b0, 5'b0, 3'd4);
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (obs !== exp_st) begin
                errors++; $display("FAIL b2b_b_cycle%0d: got %h expected %h", c, obs, exp_st);
            end
            tick();
        end
        m_bready = 1'b1;
        tick();
        m_bvalid = 1'b0; m_bready = 1'b0;
        checks++;
        exp_st = st(1'b1, 1'b0, 5'b0, 5'b0, 3'd4);
        if (obs !== exp_st) begin
            errors++; $display("FAIL b2b_reopen: got %h expected %h", obs, exp_st);
        end
        tick();
        m_awvalid = 1'b0;
        checks++;
        exp_st = st(1'b0, 1'b0, 5'b01000, 5'b0, 3'd3);
        if (obs !== exp_st || s_awaddr !== 32'h0000_3000) begin
            errors++; $display("FAIL b2b_second_aw: got %h/%h expected %h/%h",
                               obs, s_awaddr, exp_st, 32'h3000);
        end
        finish_txn();
    endtask

    task automatic test_early_w;
        m_awaddr = 32'h0000_0010; m_awvalid = 1'b1; m_wvalid = 1'b1;
        m_wdata = 32'h1234_5678; m_wstrb = 4'h3;
        #1;
        checks++;
        exp_st = st(1'b1, 1'b0, 5'b0, 5'b0, 3'd3);
        if (obs !== exp_st) begin
            errors++; $display("FAIL early_w_idle: got %h expected %h", obs, exp_st);
        end
        tick();
        m_awvalid = 1'b0;
        checks++;
        exp_st = st(1'b0, 1'b0, 5'b00001, 5'b0, 3'd0);
        if (obs !== exp_st) begin
            errors++; $display("FAIL early_w_aw: got %h expected %h", obs, exp_st);
        end
        tick();
        checks++;
        exp_st = st(1'b0, 1'b1, 5'b0, 5'b00001, 3'd0);
        if (obs !== exp_st || s_wdata !== 32'h1234_5678 || s_wstrb !== 4'h3) begin
            errors++; $display("FAIL early_w_w: got %h/%h/%h expected %h/%h/%h",
                               obs, s_wdata, s_wstrb, exp_st, 32'h12345678, 4'h3);
        end
        tick();
        m_wvalid = 1'b0; m_bvalid = 1'b1; m_bready = 1'b1;
        tick();
        m_bvalid = 1'b0; m_bready = 1'b0;
    endtask

    task automatic test_reset_mid;
        m_awaddr = 32'h0000_1000; m_awvalid = 1'b1;
        tick();
        m_awvalid = 1'b0; m_wvalid = 1'b1;
        tick();
        checks++;
        exp_st = st(1'b0, 1'b1, 5'b0, 5'b00010, 3'd1);
        if (obs !== exp_st) begin
            errors++; $display("FAIL rst_mid_in_w: got %h expected %h", obs, exp_st);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        exp_st = st(1'b1, 1'b0, 5'b0, 5'b0, 3'd0);
        if (obs !== exp_st || s_awaddr !== 32'h0) begin
            errors++; $display("FAIL rst_mid_async: got %h/%h expected %h/%h",
                               obs, s_awaddr, exp_st, 32'h0);
        end
        m_wvalid = 1'b0;
        tick();
        rst_n = 1'b1; m_awaddr = 32'h0000_2000; m_awvalid = 1'b1;
        tick();
        m_awvalid = 1'b0;
        checks++;
        exp_st = st(1'b0, 1'b0, 5'b00100, 5'b0, 3'd2);
        if (obs !== exp_st) begin
            errors++; $display("FAIL rst_mid_first_accept: got %h expected %h", obs, exp_st);
        end
        finish_txn();
        checks++;
        exp_st = st(1'b1, 1'b0, 5'b0, 5'b0, 3'd2);
        if (obs !== exp_st) begin
            errors++; $display("FAIL rst_mid_complete: got %h expected %h", obs, exp_st);
        end
    endtask

    initial begin
        test_reset();
        test_mapped_write();
        test_decode();
        test_backpressure();
        test_back_to_back();
        test_early_w();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
